time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
User-interface sequencer for the calendar/time counter.
- Takes two button levels (mode, increment) and walks the user through setting year, month, day, hour and minute in shadow registers.
- On completion, issues a single-cycle parallel load into the counter.
- Drives field-select and blink indications for the 7-segment display path.
- Sits between the synchronised push-buttons and the counter's load port.

Parameters:
- TIMEOUT, 60: idle cycles in any set state without a button edge before aborting to RUN with no load.
- BLINK_DIV, 2: cycles per half-period of the blink output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- btn_mode  in  1  mode button level, already synchronised and debounced
- btn_inc  in  1  increment button level, already synchronised and debounced
- cur_sec  in  6  live seconds from counter
- cur_min  in  6  live minutes
- cur_hour  in  5  live hours
- cur_day  in  5  live day, 1..31
- cur_month  in  4  live month, 1..12
- cur_year  in  14  live year, 0..9999
- set_active  out  1  high in any set state
- field_sel  out  3  0=none, 1=year, 2=month, 3=day, 4=hour, 5=min
- blink  out  1  display-blank strobe for the selected field
- load  out  1  one-cycle pulse; counter takes ld_* values
- ld_sec  out  6  always 0 at commit
- ld_min  out  6  shadow minute
- ld_hour  out  5  shadow hour
- ld_day  out  5  shadow day
- ld_month  out  4  shadow month
- ld_year  out  14  shadow year

Behaviour:
- Reset (async): state=RUN; set_active, field_sel, blink, load = 0; shadow registers and all ld_* = 0; edge registers = 0; idle and blink counters = 0.
- Edge detect: rise = level high now AND registered level low last cycle. Holding a button produces one event only.
- States: RUN, SET_YEAR, SET_MONTH, SET_DAY, SET_HOUR, SET_MIN, COMMIT.
- RUN:
  - mode rise: capture cur_* into shadows, go to SET_YEAR next cycle.
  - inc rise: ignored.
- Set states:
  - mode rise advances year -> month -> day -> hour -> min -> COMMIT.
  - inc rise increments the selected shadow by 1, visible next cycle.
- Increment wrap rules:
  - year 9999 -> 0
  - month 12 -> 1
  - hour 23 -> 0
  - min 59 -> 0
  - day at dim -> 1, where dim = days in shadow month for shadow year.
- Days in month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 if year mod 4 == 0, else 28.
- Day clamp: on the transition SET_MONTH -> SET_DAY, if shadow day > dim, set shadow day = dim.
- Simultaneous mode rise and inc rise in the same cycle: mode wins, increment discarded.
- COMMIT:
  - load=1 for exactly one cycle, with ld_* = shadows and ld_sec = 0.
  - Then RUN. field_sel = 0 during COMMIT.
- ld_* are continuously driven from shadows. They are meaningful only while load=1.
- Timeout:
  - The idle counter clears on any button rise and on entry to SET_YEAR.
  - It increments each cycle in a set state.
  - Reaching TIMEOUT-1 sends the FSM to RUN next cycle with no load pulse, and the shadows are discarded.
- Blink:
  - While set_active, blink toggles every BLINK_DIV cycles, starting at 0 on entry to SET_YEAR.
  - blink is forced 0 in RUN and COMMIT.
  - The blink counter restarts on every field change.
- cur_* are sampled only at RUN -> SET_YEAR; later changes are ignored.
- Reset mid-set returns to RUN immediately with no load pulse.

Test Plan:
- After reset, hold btn_mode high for 10 cycles -> exactly one transition RUN -> SET_YEAR; field_sel=1, set_active=1.
- cur=23:59:xx 31/12/9999: mode, inc (year 9999 -> 0), mode, inc (month 12 -> 1), mode, mode, mode, mode -> one-cycle load with ld_year=0, ld_month=1, ld_day=31, ld_hour=23, ld_min=59, ld_sec=0.
- cur day 31, month 1, year 2023: mode, mode, inc (month -> 2), mode -> shadow day clamped to 28; same sequence with year 2024 -> day clamped to 29.
- In SET_DAY with day=30, month=4: inc -> day=1. In SET_MIN with min=59: inc -> min=0; hour unchanged.
- btn_mode and btn_inc rise in the same cycle in SET_HOUR -> field_sel goes 4 -> 5, hour unchanged.
- Enter SET_MONTH, then no input for TIMEOUT cycles -> returns to RUN, load never asserts, set_active=0, blink=0.

Source files
------------

// File: rtl/time_set_if.sv
// Button, live-time and load bundle between the set sequencer
// and its neighbours (push-button sync, calendar counter, display).
interface time_set_if;
   logic        btn_mode;
   logic        btn_inc;
   logic [5:0]  cur_sec;
   logic [5:0]  cur_min;
   logic [4:0]  cur_hour;
   logic [4:0]  cur_day;
   logic [3:0]  cur_month;
   logic [13:0] cur_year;
   logic        set_active;
   logic [2:0]  field_sel;
   logic        blink;
   logic        load;
   logic [5:0]  ld_sec;
   logic [5:0]  ld_min;
   logic [4:0]  ld_hour;
   logic [4:0]  ld_day;
   logic [3:0]  ld_month;
   logic [13:0] ld_year;

   modport master (
      output btn_mode, btn_inc,
      output cur_sec, cur_min, cur_hour,
      output cur_day, cur_month, cur_year,
      input  set_active, field_sel, blink, load,
      input  ld_sec, ld_min, ld_hour,
      input  ld_day, ld_month, ld_year
   );

   modport slave (
      input  btn_mode, btn_inc,
      input  cur_sec, cur_min, cur_hour,
      input  cur_day, cur_month, cur_year,
      output set_active, field_sel, blink, load,
      output ld_sec, ld_min, ld_hour,
      output ld_day, ld_month, ld_year
   );
endinterface

// File: rtl/time_set_ctrl.sv
// Time/date set sequencer: walks the user through year..minute shadows
// and issues a single-cycle parallel load into the calendar counter.
module time_set_ctrl #(
   parameter int TIMEOUT   = 60,
   parameter int BLINK_DIV = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   time_set_if.slave bus
);

   localparam int IW = $clog2(TIMEOUT + 1);
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   typedef enum logic [2:0] {
      RUN, SET_YEAR, SET_MONTH, SET_DAY,
      SET_HOUR, SET_MIN, COMMIT
   } state_t;

   state_t        state;
   logic          mode_q;
   logic          inc_q;
   logic          mode_rise;
   logic          inc_rise;
   logic [IW-1:0] idle;
   logic [BW-1:0] bcnt;
   logic [13:0]   sh_year;
   logic [3:0]    sh_month;
   logic [4:0]    sh_day;
   logic [4:0]    sh_hour;
   logic [5:0]    sh_min;
   logic [4:0]    dim;

   assign mode_rise = bus.btn_mode & ~mode_q;
   assign inc_rise  = bus.btn_inc & ~inc_q;

   assign bus.ld_sec   = '0;
   assign bus.ld_min   = sh_min;
   assign bus.ld_hour  = sh_hour;
   assign bus.ld_day   = sh_day;
   assign bus.ld_month = sh_month;
   assign bus.ld_year  = sh_year;

   // Leap rule is year mod 4 only; no century exceptions.
   always_comb begin
      dim = 5'd31;
      case (sh_month)
         4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
         4'd2: dim = (sh_year[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default: dim = 5'd31;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= RUN;
         mode_q         <= 1'b0;
         inc_q          <= 1'b0;
         idle           <= '0;
         bcnt           <= '0;
         sh_year        <= '0;
         sh_month       <= '0;
         sh_day         <= '0;
         sh_hour        <= '0;
         sh_min         <= '0;
         bus.set_active <= 1'b0;
         bus.field_sel  <= '0;
         bus.blink      <= 1'b0;
         bus.load       <= 1'b0;
      end else begin
         mode_q   <= bus.btn_mode;
         inc_q    <= bus.btn_inc;
         bus.load <= 1'b0;
         case (state)
            RUN: begin
               if (mode_rise) begin
                  sh_year        <= bus.cur_year;
                  sh_month       <= bus.cur_month;
                  sh_day         <= bus.cur_day;
                  sh_hour        <= bus.cur_hour;
                  sh_min         <= bus.cur_min;
                  state          <= SET_YEAR;
                  bus.set_active <= 1'b1;
                  bus.field_sel  <= 3'd1;
                  bus.blink      <= 1'b0;
                  idle           <= '0;
                  bcnt           <= '0;
               end
            end
            COMMIT: begin
               state          <= RUN;
               bus.set_active <= 1'b0;
               bus.field_sel  <= '0;
               bus.blink      <= 1'b0;
            end
            default: begin
               if (mode_rise) begin
                  idle      <= '0;
                  bcnt      <= '0;
                  bus.blink <= 1'b0;
                  if (state == SET_MONTH && sh_day > dim)
                     sh_day <= dim;
                  if (state == SET_MIN) begin
                     state          <= COMMIT;
                     bus.load       <= 1'b1;
                     bus.set_active <= 1'b0;
                     bus.field_sel  <= '0;
                  end else begin
                     state         <= state_t'(state + 3'd1);
                     bus.field_sel <= bus.field_sel + 3'd1;
                  end
               end else if (!inc_rise && idle == IDLE_MAX) begin
                  state          <= RUN;
                  bus.set_active <= 1'b0;
                  bus.field_sel  <= '0;
                  bus.blink      <= 1'b0;
                  idle           <= '0;
                  bcnt           <= '0;
                  sh_year        <= '0;
                  sh_month       <= '0;
                  sh_day         <= '0;
                  sh_hour        <= '0;
                  sh_min         <= '0;
               end else begin
                  idle <= inc_rise ? '0 : idle + 1'b1;
                  if (bcnt == BLINK_MAX) begin
                     bcnt      <= '0;
                     bus.blink <= ~bus.blink;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
                  if (inc_rise) begin
                     case (state)
                        SET_YEAR:
                           sh_year <= (sh_year >= 14'd9999) ?
                                      '0 : sh_year + 14'd1;
                        SET_MONTH:
                           sh_month <= (sh_month >= 4'd12) ?
                                       4'd1 : sh_month + 4'd1;
                        SET_DAY:
                           sh_day <= (sh_day >= dim) ?
                                     5'd1 : sh_day + 5'd1;
                        SET_HOUR:
                           sh_hour <= (sh_hour >= 5'd23) ?
                                      '0 : sh_hour + 5'd1;
                        SET_MIN:
                           sh_min <= (sh_min >= 6'd59) ?
                                     '0 : sh_min + 6'd1;
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: vector table, directed corner sequences
// and a randomized run against a behavioural model.
module tb_time_set_ctrl;

   localparam int TIMEOUT   = 60;
   localparam int BLINK_DIV = 2;

   logic clk = 1'b0;
   logic rst_n;

   time_set_if bus ();

   time_set_ctrl #(
      .TIMEOUT   (TIMEOUT),
      .BLINK_DIV (BLINK_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int nerr = 0;
   int nchk = 0;

   // Load-pulse monitor, sampled mid-cycle.
   int load_tot = 0;
   int s_year, s_month, s_day, s_hour, s_min, s_sec;
   always @(negedge clk) begin
      if (bus.load) begin
         load_tot++;
         s_year  = bus.ld_year;
         s_month = bus.ld_month;
         s_day   = bus.ld_day;
         s_hour  = bus.ld_hour;
         s_min   = bus.ld_min;
         s_sec   = bus.ld_sec;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cur(input int y, input int mo, input int d,
                          input int h, input int mi, input int s);
      bus.cur_year  = 14'(y);
      bus.cur_month = 4'(mo);
      bus.cur_day   = 5'(d);
      bus.cur_hour  = 5'(h);
      bus.cur_min   = 6'(mi);
      bus.cur_sec   = 6'(s);
   endtask

   task automatic do_reset();
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic press(input bit m, input bit i);
      bus.btn_mode = m;
      bus.btn_inc  = i;
      step();
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      step();
   endtask

   task automatic chk_load(input string tag, input int base,
                           input int y, input int mo, input int d,
                           input int h, input int mi);
      chk({tag, "_loads"}, load_tot - base, 1);
      chk({tag, "_year"}, s_year, y);
      chk({tag, "_month"}, s_month, mo);
      chk({tag, "_day"}, s_day, d);
      chk({tag, "_hour"}, s_hour, h);
      chk({tag, "_min"}, s_min, mi);
      chk({tag, "_sec"}, s_sec, 0);
   endtask

   // Behavioural model: phase 0=run, 1..5=field, 6=commit.
   int  m_ph, m_idle, m_age;
   int  sh [1:5];
   bit  m_pm, m_pi;

   function automatic int dim_of(input int mo, input int y);
      if (mo == 2) return (y % 4 == 0) ? 29 : 28;
      if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
      return 31;
   endfunction

   task automatic model_reset();
      m_ph = 0;
      m_idle = 0;
      m_age = 0;
      m_pm = 0;
      m_pi = 0;
      for (int k = 1; k <= 5; k++) sh[k] = 0;
   endtask

   task automatic model_step(input bit md, input bit in);
      bit mr, ir;
      int dm;
      mr = md && !m_pm;
      ir = in && !m_pi;
      m_pm = md;
      m_pi = in;
      if (m_ph == 0) begin
         if (mr) begin
            sh[1] = int'(bus.cur_year);
            sh[2] = int'(bus.cur_month);
            sh[3] = int'(bus.cur_day);
            sh[4] = int'(bus.cur_hour);
            sh[5] = int'(bus.cur_min);
            m_ph = 1;
            m_idle = 0;
            m_age = 0;
         end
      end else if (m_ph == 6) begin
         m_ph = 0;
      end else if (mr) begin
         dm = dim_of(sh[2], sh[1]);
         if (m_ph == 2 && sh[3] > dm) sh[3] = dm;
         m_ph++;
         m_idle = 0;
         m_age = 0;
      end else if (ir) begin
         case (m_ph)
            1: sh[1] = (sh[1] + 1) % 10000;
            2: sh[2] = sh[2] % 12 + 1;
            3: sh[3] = (sh[3] >= dim_of(sh[2], sh[1])) ? 1 : sh[3] + 1;
            4: sh[4] = (sh[4] + 1) % 24;
            default: sh[5] = (sh[5] + 1) % 60;
         endcase
         m_idle = 0;
         m_age++;
      end else if (m_idle == TIMEOUT - 1) begin
         m_ph = 0;
      end else begin
         m_idle++;
         m_age++;
      end
   endtask

   typedef struct {
      bit mode;
      bit inc;
      bit sa;
      int fs;
      bit bl;
      bit ld;
   } vec_t;

   vec_t tbl [18];

   initial begin
      int base, entries, prev_fs;
      bit set_now, quiet;
      int e_sa, e_fs, e_bl;

      tbl[0]  = '{0, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 0, 0, 0};
      tbl[2]  = '{1, 1, 1, 1, 0, 0};
      tbl[3]  = '{1, 1, 1, 1, 0, 0};
      tbl[4]  = '{1, 0, 1, 1, 1, 0};
      tbl[5]  = '{0, 0, 1, 1, 1, 0};
      tbl[6]  = '{0, 0, 1, 1, 0, 0};
      tbl[7]  = '{1, 0, 1, 2, 0, 0};
      tbl[8]  = '{0, 1, 1, 2, 0, 0};
      tbl[9]  = '{1, 1, 1, 3, 0, 0};
      tbl[10] = '{0, 0, 1, 3, 0, 0};
      tbl[11] = '{1, 0, 1, 4, 0, 0};
      tbl[12] = '{0, 0, 1, 4, 0, 0};
      tbl[13] = '{1, 0, 1, 5, 0, 0};
      tbl[14] = '{0, 0, 1, 5, 0, 0};
      tbl[15] = '{1, 0, 0, 0, 0, 1};
      tbl[16] = '{0, 0, 0, 0, 0, 0};
      tbl[17] = '{0, 0, 0, 0, 0, 0};

      set_cur(2020, 6, 15, 12, 34, 56);
      bus.btn_mode = 1'b0;
      bus.btn_inc  = 1'b0;
      rst_n = 1'b0;
      #3;
      chk("rst_set_active", bus.set_active, 0);
      chk("rst_field_sel", bus.field_sel, 0);
      chk("rst_blink", bus.blink, 0);
      chk("rst_load", bus.load, 0);
      chk("rst_ld_year", bus.ld_year, 0);
      chk("rst_ld_min", bus.ld_min, 0);
      step();
      rst_n = 1'b1;
      step();

      // Table walk through every field with blink phases.
      base = load_tot;
      for (int i = 0; i < 18; i++) begin
         bus.btn_mode = tbl[i].mode;
         bus.btn_inc  = tbl[i].inc;
         step();
         chk($sformatf("tbl%0d_sa", i), bus.set_active, tbl[i].sa);
         chk($sformatf("tbl%0d_fs", i), bus.field_sel, tbl[i].fs);
         chk($sformatf("tbl%0d_bl", i), bus.blink, tbl[i].bl);
         chk($sformatf("tbl%0d_ld", i), bus.load, tbl[i].ld);
      end
      chk_load("tbl", base, 2020, 7, 15, 12, 34);

      // Held mode button gives exactly one entry.
      do_reset();
      entries = 0;
      prev_fs = 0;
      bus.btn_mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.field_sel == 3'd1 && prev_fs == 0) entries++;
         prev_fs = int'(bus.field_sel);
      end
      bus.btn_mode = 1'b0;
      chk("hold_entries", entries, 1);
      chk("hold_fs", bus.field_sel, 1);
      chk("hold_sa", bus.set_active, 1);

      // Year and month wrap.
      do_reset();
      set_cur(9999, 12, 31, 23, 59, 17);
      base = load_tot;
      press(1, 0);
      press(0, 1);
      press(1, 0);
      press(0, 1);
      repeat (4) press(1, 0);
      chk_load("wrap", base, 0, 1, 31, 23, 59);

      // Day clamp into February, common and leap year.
      for (int yy = 2023; yy <= 2024; yy++) begin
         do_reset();
         set_cur(yy, 1, 31, 8, 15, 0);
         base = load_tot;
         press(1, 0);
         press(1, 0);
         press(0, 1);
         press(1, 0);
         repeat (3) press(1, 0);
         chk_load($sformatf("clamp%0d", yy), base, yy, 2, yy % 4 == 0 ? 29 : 28, 8, 15);
      end

      // Day wrap in a 30-day month, minute wrap.
      do_reset();
      set_cur(2021, 4, 30, 7, 59, 0);
      base = load_tot;
      repeat (3) press(1, 0);
      press(0, 1);
      repeat (2) press(1, 0);
      press(0, 1);
      press(1, 0);
      chk_load("dwrap", base, 2021, 4, 1, 7, 0);

      // Simultaneous rise in SET_HOUR: mode wins.
      do_reset();
      set_cur(2000, 3, 3, 5, 10, 0);
      base = load_tot;
      repeat (4) press(1, 0);
      chk("sim_fs_before", bus.field_sel, 4);
      press(1, 1);
      chk("sim_fs_after", bus.field_sel, 5);
      press(1, 0);
      chk_load("sim", base, 2000, 3, 3, 5, 10);

      // Timeout out of SET_MONTH.
      do_reset();
      base = load_tot;
      press(1, 0);
      press(1, 0);
      repeat (TIMEOUT - 2) step();
      chk("to_still_set", bus.set_active, 1);
      chk("to_still_fs", bus.field_sel, 2);
      step();
      chk("to_sa", bus.set_active, 0);
      chk("to_fs", bus.field_sel, 0);
      chk("to_bl", bus.blink, 0);
      chk("to_loads", load_tot - base, 0);

      // Asynchronous reset mid-set.
      base = load_tot;
      press(1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_sa", bus.set_active, 0);
      chk("arst_fs", bus.field_sel, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("arst_loads", load_tot - base, 0);

      // Randomized run against the model.
      do_reset();
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         quiet = (c % 700) >= 610;
         if (!quiet && $urandom_range(0, 5) == 0)
            bus.btn_mode = ~bus.btn_mode;
         if (!quiet && $urandom_range(0, 3) == 0)
            bus.btn_inc = ~bus.btn_inc;
         set_cur(($urandom_range(0, 3) == 0) ? 9999 : $urandom_range(0, 9999),
                 ($urandom_range(0, 2) == 0) ? 2 : $urandom_range(1, 12),
                 ($urandom_range(0, 2) == 0) ? 31 : $urandom_range(1, 31),
                 ($urandom_range(0, 3) == 0) ? 23 : $urandom_range(0, 23),
                 ($urandom_range(0, 3) == 0) ? 59 : $urandom_range(0, 59),
                 $urandom_range(0, 59));
         model_step(bus.btn_mode, bus.btn_inc);
         step();
         set_now = (m_ph >= 1 && m_ph <= 5);
         e_sa = set_now ? 1 : 0;
         e_fs = set_now ? m_ph : 0;
         e_bl = set_now ? (m_age / BLINK_DIV) % 2 : 0;
         chk("rnd_sa", bus.set_active, e_sa);
         chk("rnd_fs", bus.field_sel, e_fs);
         chk("rnd_bl", bus.blink, e_bl);
         chk("rnd_load", bus.load, (m_ph == 6) ? 1 : 0);
         if (m_ph == 6) begin
            chk("rnd_ld_year", bus.ld_year, sh[1]);
            chk("rnd_ld_month", bus.ld_month, sh[2]);
            chk("rnd_ld_day", bus.ld_day, sh[3]);
            chk("rnd_ld_hour", bus.ld_hour, sh[4]);
            chk("rnd_ld_min", bus.ld_min, sh[5]);
            chk("rnd_ld_sec", bus.ld_sec, 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
